// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end for a single bit-serial full adder.
// The winner's operands are captured and added LSB-first, one bit per clock.
module serial_add_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         done,
    output logic         done_id
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (W > 1) ? W - 1 : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD    = 2'd1,
        DONE_S = 2'd2
    } state_t;

    state_t         state_reg;
    logic [W-1:0]   a_sh_reg;
    logic [W-1:0]   b_sh_reg;
    logic [RW-1:0]  res_reg;
    logic           carry_reg;
    logic [CW-1:0]  cnt_reg;
    logic           rr_reg;
    logic           owner_reg;

    logic           win1;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic           s_bit;
    logic           c_next;
    logic [W-1:0]   res_next;
    logic [RW-1:0]  res_shift;

    // On a tie the requester that was not granted last wins; rr_reg holds the last winner.
    assign win1 = req1 & (~req0 | ~rr_reg);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_opsel
            assign a_sel[gi] = win1 ? a1[gi] : a0[gi];
            assign b_sel[gi] = win1 ? b1[gi] : b0[gi];
        end
    endgenerate

    assign s_bit  = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
    assign c_next = (a_sh_reg[0] & b_sh_reg[0]) |
                    (a_sh_reg[0] & carry_reg)   |
                    (b_sh_reg[0] & carry_reg);

    // The new bit enters at the MSB so that after W shifts bit 0 sits at the LSB.
    generate
        if (W > 1) begin : g_res_wide
            assign res_next  = {s_bit, res_reg};
            assign res_shift = res_next[W-1:1];
        end else begin : g_res_one
            assign res_next  = s_bit;
            assign res_shift = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            rr_reg    <= 1'b1;
            owner_reg <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req0 | req1) begin
                        a_sh_reg  <= a_sel;
                        b_sh_reg  <= b_sel;
                        carry_reg <= 1'b0;
                        cnt_reg   <= '0;
                        rr_reg    <= win1;
                        owner_reg <= win1;
                        gnt0      <= ~win1;
                        gnt1      <= win1;
                        busy      <= 1'b1;
                        state_reg <= ADD;
                    end
                end
                ADD: begin
                    carry_reg <= c_next;
                    res_reg   <= res_shift;
                    a_sh_reg  <= a_sh_reg >> 1;
                    b_sh_reg  <= b_sh_reg >> 1;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_BIT) begin
                        sum       <= res_next;
                        cout      <= c_next;
                        done_id   <= owner_reg;
                        done      <= 1'b1;
                        state_reg <= DONE_S;
                    end
                end
                DONE_S: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter: a W=8 instance and a W=1 instance.
module tb_serial_add_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, busy, cout, done, done_id;
    logic [7:0] sum;

    logic       w1_req0, w1_req1;
    logic [0:0] w1_a0, w1_b0, w1_a1, w1_b1;
    logic       w1_gnt0, w1_gnt1, w1_busy, w1_cout, w1_done, w1_done_id;
    logic [0:0] w1_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_add_arbiter #(.W(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .sum(sum), .cout(cout), .done(done), .done_id(done_id)
    );

    serial_add_arbiter #(.W(1)) dut_w1 (
        .clk(clk), .reset(reset),
        .req0(w1_req0), .a0(w1_a0), .b0(w1_b0),
        .req1(w1_req1), .a1(w1_a1), .b1(w1_b1),
        .gnt0(w1_gnt0), .gnt1(w1_gnt1), .busy(w1_busy),
        .sum(w1_sum), .cout(w1_cout), .done(w1_done), .done_id(w1_done_id)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done is seen; n = -1 when the budget runs out.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n > 0)
            $display("txn id=%0d sum=%h cout=%b edges=%0d", done_id, sum, cout, n);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        w1_req0 = 0; w1_req1 = 0; w1_a0 = 0; w1_b0 = 0; w1_a1 = 0; w1_b1 = 0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        total++;
        if ({gnt0, gnt1, busy, done, done_id, cout} !== 6'b0 || sum !== 8'h00) begin
            bad++;
            $display("FAIL reset_w8: got gnt=%b%b busy=%b done=%b id=%b cout=%b sum=%h, want all 0",
                     gnt0, gnt1, busy, done, done_id, cout, sum);
        end
        total++;
        if ({w1_gnt0, w1_gnt1, w1_busy, w1_done, w1_done_id, w1_cout, w1_sum} !== 7'b0) begin
            bad++;
            $display("FAIL reset_w1: got outputs not all zero");
        end
    endtask

    task automatic test_single;
        logic early;
        req0 = 1; a0 = 8'h5A; b0 = 8'hC3;
        tick();
        $display("txn grant0 a=5a b=c3");
        total++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_gnt: got gnt0=%b gnt1=%b busy=%b, want 1 0 1", gnt0, gnt1, busy);
        end
        req0 = 0; a0 = 8'hFF; b0 = 8'hFF;
        early = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (done !== 1'b0 || sum !== 8'h00 || gnt0 !== 1'b0) early = 1'b1;
        end
        total++;
        if (early) begin
            bad++;
            $display("FAIL single_hold: sum/done changed before the final bit edge, sum=%h", sum);
        end
        tick();
        $display("txn id=%0d sum=%h cout=%b", done_id, sum, cout);
        total++;
        if (done !== 1'b1 || sum !== 8'h1D || cout !== 1'b1 || done_id !== 1'b0) begin
            bad++;
            $display("FAIL single_result: got done=%b sum=%h cout=%b id=%b, want 1 1d 1 0",
                     done, sum, cout, done_id);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_end: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_tie;
        int n;
        do_reset();
        req0 = 1; a0 = 8'h10; b0 = 8'h20;
        req1 = 1; a1 = 8'h0F; b1 = 8'hF0;
        tick();
        total++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL tie1_gnt: got gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
        end
        req0 = 0;
        wait_done(n);
        total++;
        if (n !== 8 || sum !== 8'h30 || cout !== 1'b0 || done_id !== 1'b0) begin
            bad++;
            $display("FAIL tie1_result: got edges=%0d sum=%h cout=%b id=%b, want 8 30 0 0",
                     n, sum, cout, done_id);
        end
        tick();
        total++;
        if (gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL tie_done_gnt: got gnt1=%b in done cycle, want 0", gnt1);
        end
        tick();
        total++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            bad++;
            $display("FAIL tie2_gnt: got gnt0=%b gnt1=%b, want 0 1", gnt0, gnt1);
        end
        req1 = 0;
        wait_done(n);
        total++;
        if (n !== 8 || sum !== 8'hFF || cout !== 1'b0 || done_id !== 1'b1) begin
            bad++;
            $display("FAIL tie2_result: got edges=%0d sum=%h cout=%b id=%b, want 8 ff 0 1",
                     n, sum, cout, done_id);
        end
        tick();
        req0 = 1; a0 = 8'h01; b0 = 8'h01;
        req1 = 1; a1 = 8'h02; b1 = 8'h02;
        tick();
        total++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL tie3_gnt: got gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
        end
        req0 = 0; req1 = 0;
        wait_done(n);
        total++;
        if (sum !== 8'h02 || done_id !== 1'b0) begin
            bad++;
            $display("FAIL tie3_result: got sum=%h id=%b, want 02 0", sum, done_id);
        end
        tick();
    endtask

    task automatic test_values;
        int n;
        req1 = 1; a1 = 8'hFF; b1 = 8'h01;
        tick();
        req1 = 0;
        wait_done(n);
        total++;
        if (n !== 8 || sum !== 8'h00 || cout !== 1'b1 || done_id !== 1'b1) begin
            bad++;
            $display("FAIL wrap: got edges=%0d sum=%h cout=%b id=%b, want 8 00 1 1",
                     n, sum, cout, done_id);
        end
        tick();
        req0 = 1; a0 = 8'h00; b0 = 8'h00;
        tick();
        req0 = 0;
        wait_done(n);
        total++;
        if (n !== 8 || sum !== 8'h00 || cout !== 1'b0 || done_id !== 1'b0) begin
            bad++;
            $display("FAIL zero: got edges=%0d sum=%h cout=%b id=%b, want 8 00 0 0",
                     n, sum, cout, done_id);
        end
        tick();
    endtask

    task automatic test_mid_req;
        int  n;
        logic saw;
        req0 = 1; a0 = 8'h37; b0 = 8'h48;
        tick();
        req0 = 0;
        tick(); tick(); tick();
        req1 = 1; a1 = 8'h01; b1 = 8'h02;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt1 === 1'b1) saw = 1'b1;
            if (done === 1'b1) break;
        end
        total++;
        if (saw !== 1'b0 || done !== 1'b1 || sum !== 8'h7F || cout !== 1'b0 || done_id !== 1'b0) begin
            bad++;
            $display("FAIL mid_first: got early_gnt1=%b done=%b sum=%h cout=%b id=%b, want 0 1 7f 0 0",
                     saw, done, sum, cout, done_id);
        end
        tick();
        total++;
        if (gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL mid_done_gnt: got gnt1=%b, want 0", gnt1);
        end
        tick();
        total++;
        if (gnt1 !== 1'b1) begin
            bad++;
            $display("FAIL mid_gnt1: got gnt1=%b, want 1", gnt1);
        end
        req1 = 0;
        wait_done(n);
        total++;
        if (n !== 8 || sum !== 8'h03 || done_id !== 1'b1) begin
            bad++;
            $display("FAIL mid_second: got edges=%0d sum=%h id=%b, want 8 03 1", n, sum, done_id);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int  n;
        logic saw;
        req0 = 1; a0 = 8'hAA; b0 = 8'h56;
        tick();
        req0 = 0;
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || done !== 1'b0 || gnt0 !== 1'b0) begin
            bad++;
            $display("FAIL abort: got busy=%b sum=%h cout=%b done=%b gnt0=%b, want 0 00 0 0 0",
                     busy, sum, cout, done, gnt0);
        end
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) reset = 1'b1;
            tick();
            if (done === 1'b1 || gnt0 === 1'b1) saw = 1'b1;
        end
        total++;
        if (saw !== 1'b0 || sum !== 8'h00) begin
            bad++;
            $display("FAIL abort_quiet: got stray_done_or_gnt=%b sum=%h, want 0 00", saw, sum);
        end
        req0 = 1; a0 = 8'd3; b0 = 8'd4;
        tick();
        req0 = 0;
        wait_done(n);
        total++;
        if (n !== 8 || sum !== 8'd7 || cout !== 1'b0) begin
            bad++;
            $display("FAIL after_abort: got edges=%0d sum=%h cout=%b, want 8 07 0", n, sum, cout);
        end
        tick();
    endtask

    task automatic test_w1;
        w1_req0 = 1; w1_a0 = 1'b1; w1_b0 = 1'b1;
        tick();
        total++;
        if (w1_gnt0 !== 1'b1 || w1_done !== 1'b0 || w1_busy !== 1'b1) begin
            bad++;
            $display("FAIL w1_gnt: got gnt0=%b done=%b busy=%b, want 1 0 1", w1_gnt0, w1_done, w1_busy);
        end
        w1_req0 = 0;
        tick();
        $display("txn w1 id=%0d sum=%b cout=%b", w1_done_id, w1_sum, w1_cout);
        total++;
        if (w1_done !== 1'b1 || w1_sum !== 1'b0 || w1_cout !== 1'b1 || w1_done_id !== 1'b0) begin
            bad++;
            $display("FAIL w1_result: got done=%b sum=%b cout=%b id=%b, want 1 0 1 0",
                     w1_done, w1_sum, w1_cout, w1_done_id);
        end
        tick();
        total++;
        if (w1_done !== 1'b0 || w1_busy !== 1'b0) begin
            bad++;
            $display("FAIL w1_end: got done=%b busy=%b, want 0 0", w1_done, w1_busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_values();
        test_mid_req();
        test_reset_mid();
        test_w1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
